// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives freeze/flush of the IF/ID and ID/EX registers from
// load-use/RAW hazards, taken branches and SRAM waits; keeps stall/flush stats and a timeout flag.
module hazard_ctrl #(
    parameter bit FORWARDING = 1'b0,
    parameter int MAX_WAIT   = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic             exe_b,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic             dbg_state
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic hazard_src1, hazard_src2, hazard, mem_wait;
    logic stall_act, flush_act;

    // With forwarding only a load in EXE can't be bypassed; otherwise any pending write stalls.
    always_comb begin
        if (FORWARDING) begin
            hazard_src1 = id_use_src1 & exe_mem_r_en & (exe_dest == id_src1);
            hazard_src2 = id_use_src2 & exe_mem_r_en & (exe_dest == id_src2);
        end else begin
            hazard_src1 = id_use_src1 & ((exe_wb_en & (exe_dest == id_src1)) |
                                         (mem_wb_en & (mem_dest == id_src1)));
            hazard_src2 = id_use_src2 & ((exe_wb_en & (exe_dest == id_src2)) |
                                         (mem_wb_en & (mem_dest == id_src2)));
        end
        hazard   = hazard_src1 | hazard_src2;
        mem_wait = mem_req & ~mem_ready;
    end

    always_comb begin
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        stall_act   = 1'b0;
        flush_act   = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pipe_freeze = 1'b1;
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
            end else if (exe_b) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_act  = 1'b1;
            end else if (hazard) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_flush  = 1'b1;
                stall_act   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready || !mem_req) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (stall_act && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_act && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        // Flag rises on the edge where the wait count lands on the limit.
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: u0 is a no-forwarding, short-timeout, 2-bit-counter instance; u1 has
// forwarding and default limits. Both see the same inputs.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_use_src1, id_use_src2, exe_wb_en, exe_mem_r_en, exe_b;
    logic       mem_wb_en, mem_req, mem_ready;

    logic        u0_pc_freeze, u0_ifid_freeze, u0_ifid_flush, u0_idex_flush, u0_pipe_freeze;
    logic [1:0]  u0_stall_cnt, u0_flush_cnt;
    logic        u0_mem_timeout, u0_dbg_state;
    logic        u1_pc_freeze, u1_ifid_freeze, u1_ifid_flush, u1_idex_flush, u1_pipe_freeze;
    logic [15:0] u1_stall_cnt, u1_flush_cnt;
    logic        u1_mem_timeout, u1_dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FORWARDING(1'b0), .MAX_WAIT(4), .CNT_W(2)) u0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .exe_b(exe_b),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(u0_pc_freeze), .ifid_freeze(u0_ifid_freeze), .ifid_flush(u0_ifid_flush),
        .idex_flush(u0_idex_flush), .pipe_freeze(u0_pipe_freeze), .stall_cnt(u0_stall_cnt),
        .flush_cnt(u0_flush_cnt), .mem_timeout(u0_mem_timeout), .dbg_state(u0_dbg_state)
    );

    hazard_ctrl #(.FORWARDING(1'b1), .MAX_WAIT(255), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .exe_b(exe_b),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(u1_pc_freeze), .ifid_freeze(u1_ifid_freeze), .ifid_flush(u1_ifid_flush),
        .idex_flush(u1_idex_flush), .pipe_freeze(u1_pipe_freeze), .stall_cnt(u1_stall_cnt),
        .flush_cnt(u1_flush_cnt), .mem_timeout(u1_mem_timeout), .dbg_state(u1_dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 4'd0; exe_b = 1'b0;
        mem_wb_en = 1'b0; mem_dest = 4'd0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Reset cycle with everything asserted: outputs must stay 0
        exe_b = 1'b1; mem_req = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2; id_use_src1 = 1'b1;
        #2;
        chk("rst_pipe_freeze", 32'(u0_pipe_freeze), 0);
        chk("rst_ifid_flush", 32'(u0_ifid_flush), 0);
        chk("rst_pc_freeze", 32'(u1_pc_freeze), 0);
        tick();
        chk("rst_stall_cnt", 32'(u0_stall_cnt), 0);
        chk("rst_flush_cnt", 32'(u1_flush_cnt), 0);
        chk("rst_timeout", 32'(u0_mem_timeout), 0);
        chk("rst_state", 32'(u0_dbg_state), 0);
        do_reset();

        // Load-use with forwarding: one-cycle stall
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
        #1;
        chk("lu_pc_freeze", 32'(u1_pc_freeze), 1);
        chk("lu_ifid_freeze", 32'(u1_ifid_freeze), 1);
        chk("lu_idex_flush", 32'(u1_idex_flush), 1);
        chk("lu_ifid_flush", 32'(u1_ifid_flush), 0);
        chk("lu_pipe_freeze", 32'(u1_pipe_freeze), 0);
        tick();
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3;
        #1;
        chk("lu_release_pc", 32'(u1_pc_freeze), 0);
        chk("lu_release_idex", 32'(u1_idex_flush), 0);
        chk("lu_stall_cnt", 32'(u1_stall_cnt), 1);
        chk("lu_nofwd_mem_stall", 32'(u0_pc_freeze), 1);
        do_reset();

        // RAW without forwarding: stall in EXE then MEM, 2 cycles
        exe_wb_en = 1'b1; exe_dest = 4'd5; id_src2 = 4'd5; id_use_src2 = 1'b1;
        #1;
        chk("raw_exe_pc", 32'(u0_pc_freeze), 1);
        chk("raw_exe_idex", 32'(u0_idex_flush), 1);
        chk("raw_fwd_nostall", 32'(u1_pc_freeze), 0);
        tick();
        exe_wb_en = 1'b0; exe_dest = 4'd0; mem_wb_en = 1'b1; mem_dest = 4'd5;
        #1;
        chk("raw_mem_ifid", 32'(u0_ifid_freeze), 1);
        tick();
        mem_wb_en = 1'b0;
        #1;
        chk("raw_release", 32'(u0_pc_freeze), 0);
        chk("raw_stall_cnt", 32'(u0_stall_cnt), 2);
        chk("raw_fwd_stall_cnt", 32'(u1_stall_cnt), 0);
        // Unused source never stalls; R15 compares like any register
        exe_wb_en = 1'b1; exe_dest = 4'd5; id_use_src2 = 1'b0;
        #1;
        chk("unused_src", 32'(u0_pc_freeze), 0);
        exe_dest = 4'd15; id_src1 = 4'd15; id_use_src1 = 1'b1;
        #1;
        chk("r15_hazard", 32'(u0_pc_freeze), 1);
        do_reset();

        // Branch with concurrent hazard: branch wins, stall discarded
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; id_use_src1 = 1'b1;
        exe_b = 1'b1;
        #1;
        chk("br_ifid_flush", 32'(u1_ifid_flush), 1);
        chk("br_idex_flush", 32'(u1_idex_flush), 1);
        chk("br_pc_freeze", 32'(u1_pc_freeze), 0);
        chk("br_ifid_freeze", 32'(u0_ifid_freeze), 0);
        tick();
        clear_inputs();
        #1;
        chk("br_flush_cnt", 32'(u1_flush_cnt), 1);
        chk("br_stall_cnt", 32'(u1_stall_cnt), 0);
        do_reset();

        // Memory wait holds a branch for 3 cycles, then the flush goes through
        exe_b = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_pipe_freeze", 32'(u1_pipe_freeze), 1);
            chk("mw_pc_freeze", 32'(u1_pc_freeze), 1);
            chk("mw_no_flush", 32'(u1_ifid_flush), 0);
            chk("mw_no_idex", 32'(u1_idex_flush), 0);
            tick();
            chk("mw_state_wait", 32'(u1_dbg_state), 1);
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_ready_freeze", 32'(u1_pipe_freeze), 0);
        chk("mw_ready_flush", 32'(u1_ifid_flush), 1);
        tick();
        chk("mw_state_run", 32'(u1_dbg_state), 0);
        chk("mw_flush_cnt", 32'(u1_flush_cnt), 1);
        // Request completing in the same cycle: no freeze, no state change
        exe_b = 1'b0; mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rr_no_freeze", 32'(u1_pipe_freeze), 0);
        tick();
        chk("rr_state_run", 32'(u1_dbg_state), 0);
        do_reset();

        // Timeout on u0 (limit 4): flag rises after the 4th wait cycle and is sticky
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("to_not_yet", 32'(u0_mem_timeout), 0);
        tick();
        chk("to_set", 32'(u0_mem_timeout), 1);
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("to_sticky", 32'(u0_mem_timeout), 1);
        chk("to_long_limit", 32'(u1_mem_timeout), 0);
        rst = 1'b1;
        #1;
        chk("to_before_rst_edge", 32'(u0_mem_timeout), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("to_cleared", 32'(u0_mem_timeout), 0);
        do_reset();

        // Counter saturation: 5 branch cycles
        exe_b = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_flush_cnt2", 32'(u0_flush_cnt), 3);
        chk("sat_flush_cnt16", 32'(u1_flush_cnt), 5);
        // Reset in the middle of a wait
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        chk("mr_in_wait", 32'(u0_dbg_state), 1);
        rst = 1'b1;
        #1;
        chk("mr_pipe_freeze", 32'(u0_pipe_freeze), 0);
        chk("mr_pc_freeze", 32'(u0_pc_freeze), 0);
        chk("mr_ifid_flush", 32'(u1_ifid_flush), 0);
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("mr_state", 32'(u0_dbg_state), 0);
        chk("mr_flush_cnt2", 32'(u0_flush_cnt), 0);
        chk("mr_flush_cnt16", 32'(u1_flush_cnt), 0);
        chk("mr_stall_cnt", 32'(u0_stall_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control block for the 5-stage ARM core: it drives the freeze and flush inputs of the IF/ID and ID/EX stage registers. It consumes the ID/EX register outputs (`WB_EN`, `MEM_R_EN`, `Dest`, `B`), the EX/MEM write-back tag, and the MEM-stage SRAM handshake. From these it produces load-use and RAW stalls, branch flushes and memory-wait freezes. It also keeps saturating stall and flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- `FORWARDING`, default 0: 1 means a forwarding unit is present, so only load-use hazards stall; 0 means every RAW hazard against EXE/MEM stalls.
- `MAX_WAIT`, default 255: memory-wait cycles before `mem_timeout` sets.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_src1` in 4: Rn index of the instruction in ID.
- `id_src2` in 4: Rm (or Rd for STR) index of the instruction in ID.
- `id_use_src1` in 1: ID instruction reads `id_src1`.
- `id_use_src2` in 1: ID instruction reads `id_src2`.
- `exe_wb_en` in 1: `WB_EN` output of the ID/EX register.
- `exe_mem_r_en` in 1: `MEM_R_EN` output of the ID/EX register.
- `exe_dest` in 4: `Dest` output of the ID/EX register.
- `exe_b` in 1: `B` output of the ID/EX register, meaning a taken branch is in EXE.
- `mem_wb_en` in 1: write-back enable of the EX/MEM register.
- `mem_dest` in 4: destination of the EX/MEM register.
- `mem_req` in 1: MEM stage is issuing an SRAM access.
- `mem_ready` in 1: SRAM access completes this cycle.
- `pc_freeze` out 1: hold the PC register.
- `ifid_freeze` out 1: hold the IF/ID register.
- `ifid_flush` out 1: load a NOP into IF/ID.
- `idex_flush` out 1: load a bubble into ID/EX; this is the `flush` input of the ID/EX register.
- `pipe_freeze` out 1: hold every pipeline register and the PC.
- `stall_cnt` out `CNT_W`: count of hazard-stall cycles.
- `flush_cnt` out `CNT_W`: count of branch flushes.
- `mem_timeout` out 1: sticky flag for a memory wait that reached `MAX_WAIT`.

## Operation
- All freeze and flush outputs are combinational from the inputs and registered state. All of them are 0 while `rst=1`.
- Hazard term per source: `use & (match_exe | match_mem)`.
  - `FORWARDING=0`: `match_exe = exe_wb_en & exe_dest==src`; `match_mem = mem_wb_en & mem_dest==src`.
  - `FORWARDING=1`: `match_exe = exe_mem_r_en & exe_dest==src`; `match_mem = 0`.
  - `hazard` is the OR of the two source terms.
- `mem_wait = mem_req & ~mem_ready`.
- Priority, highest first:
  1. `mem_wait`: `pipe_freeze=1`, `pc_freeze=1`, `ifid_freeze=1`; all flushes 0. The branch or hazard is held and re-evaluated after the wait.
  2. `exe_b`: `ifid_flush=1`, `idex_flush=1`, freezes 0. The PC loads the branch target, and any concurrent hazard is discarded because its instruction is squashed.
  3. `hazard`: `pc_freeze=1`, `ifid_freeze=1`, `idex_flush=1`.
  4. Otherwise all outputs are 0.
- State machine, registered:
  - RUN, on `mem_wait`: go to WAIT and load `wait_cnt=1`.
  - WAIT, on `mem_ready` or `!mem_req`: go to RUN.
  - WAIT, otherwise: `wait_cnt` increments, saturating at `MAX_WAIT`.
  - Either state: when `wait_cnt` reaches `MAX_WAIT`, `mem_timeout` sets and stays set until `rst`.
- Counters:
  - `stall_cnt` increments on each cycle where priority 3 is active.
  - `flush_cnt` increments on each cycle where priority 2 is active.
  - Both saturate at all-ones and never wrap.
- Register index 15 (PC) is compared like any other register. The decoder clears `id_use_*` when R15 is not a true data source.

## Timing
- Reset values: state RUN, `wait_cnt=0`, `stall_cnt=0`, `flush_cnt=0`, `mem_timeout=0`.
- Output latency is 0 cycles. Freeze and flush are valid in the same cycle as the causing inputs and act at the next `clk` edge.
- A load-use stall with `FORWARDING=1` lasts exactly 1 cycle: after the bubble, `exe_mem_r_en` is 0.
- A RAW stall with `FORWARDING=0` lasts up to 2 cycles, while the producer passes through EXE and then MEM.
- Branch flush lasts 1 cycle, because the bubble clears `exe_b` on the next cycle.
- `mem_req & mem_ready` in the same cycle produces no freeze and no state change.
- `rst` asserted during WAIT returns to RUN and clears counters and the flag at that edge. Outputs are 0 in the reset cycle.

## Test plan
- Load-use, `FORWARDING=1`: set `exe_mem_r_en=1`, `exe_dest=3`, `id_src1=3`, `id_use_src1=1`. Required: in that cycle `pc_freeze`, `ifid_freeze` and `idex_flush` are 1. The next cycle, with `exe_mem_r_en=0`, all are 0, and `stall_cnt=1`.
- RAW, `FORWARDING=0`: producer writing R5 with `id_src2=5`. Required: stall while `exe_dest=5`, then while `mem_dest=5`, for 2 cycles in total; then release, with `stall_cnt=2`.
- Branch plus hazard: set `exe_b=1` with a matching hazard. Required: `ifid_flush=1`, `idex_flush=1`, `pc_freeze=0`, `flush_cnt=1`, `stall_cnt` unchanged.
- Memory wait: raise `mem_req=1` and hold `mem_ready=0` for 3 cycles, then raise it to 1, with `exe_b=1` throughout. Required: `pipe_freeze=1` for 3 cycles with no flush. In the `mem_ready` cycle `pipe_freeze=0` and the flush asserts. State returns to RUN.
- Timeout: `MAX_WAIT=4`, `mem_req=1`, `mem_ready=0` for 6 cycles. Required: `mem_timeout` rises after the 4th wait cycle and stays 1 after `mem_ready`. It clears only when `rst=1` is sampled.
- Saturation and reset: `CNT_W=2` with 5 branch cycles gives `flush_cnt=3`. Asserting `rst` mid-wait gives all outputs 0 in that cycle and counters 0 afterwards.
